// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end.
//   - fetch FSM state encoding (also visible on fetch_unit.state_o)
//   - NOP_INSTR: word placed in IF/ID when it is flushed or bubbled
//   - RESET_PC_DEFAULT: default PC after reset
//   - PC_INC: sequential PC increment
package cpu_pkg;

  localparam int          STATE_W          = 2;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset (clears everything)
//   flush                 drop the held instruction: valid=0, instr=NOP
//   hold                  keep the current contents (load-use stall)
//   load                  capture pc_d/pc4_d/instr_d as a valid instruction
//   pc_d, pc4_d, instr_d  incoming fetch result
//   valid_q, pc_q, pc4_q, instr_q  registered IF/ID contents
// Priority: flush > hold > load. With none asserted the register holds.
// A flush leaves the pc fields as they were; only valid/instr are cleared.
module ifid_reg
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        hold,
  input  logic        load,
  input  logic [31:0] pc_d,
  input  logic [31:0] pc4_d,
  input  logic [31:0] instr_d,
  output logic        valid_q,
  output logic [31:0] pc_q,
  output logic [31:0] pc4_q,
  output logic [31:0] instr_q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      pc4_q   <= '0;
      instr_q <= NOP_INSTR;
    end else if (flush) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end else if (!hold && load) begin
      valid_q <= 1'b1;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, redirect pending register, fetch FSM
// and the IF/ID register (ifid_reg).
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   stall_i                 load-use stall; freezes PC and IF/ID while fetching
//   redirect_i/redirect_pc_i  IF.Flush and its target
//   imem_req_o/imem_addr_o  fetch request and address (address = pc_o)
//   imem_ready_i/imem_rdata_i  fetch completion and instruction word
//   pc_o, pc_plus4_o        PC register and PC+4 (combinational, wraps)
//   ifid_*_o                IF/ID register contents
//   state_o                 current FSM state (debug)
// Handshake: imem_req_o/imem_addr_o, once asserted, stay stable up to and
// including the cycle in which imem_ready_i=1; that cycle completes the fetch.
// ready may be high in the same cycle the request is first raised.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall_i,
  input  logic                 redirect_i,
  input  logic [31:0]          redirect_pc_i,
  output logic                 imem_req_o,
  output logic [31:0]          imem_addr_o,
  input  logic                 imem_ready_i,
  input  logic [31:0]          imem_rdata_i,
  output logic [31:0]          pc_o,
  output logic [31:0]          pc_plus4_o,
  output logic                 ifid_valid_o,
  output logic [31:0]          ifid_pc_o,
  output logic [31:0]          ifid_pc4_o,
  output logic [31:0]          ifid_instr_o,
  output logic [STATE_W-1:0]   state_o
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pend_pc;
  logic [31:0]  pc_plus4;
  logic         req_q;
  logic         ifid_flush;
  logic         ifid_hold;
  logic         ifid_load;

  assign pc_plus4    = pc + PC_INC;
  assign pc_o        = pc;
  assign pc_plus4_o  = pc_plus4;
  assign imem_addr_o = pc;
  assign imem_req_o  = req_q;
  assign state_o     = state;

  // IF/ID control. Outside S_FETCH the register only ever shows a bubble;
  // in S_FETCH a missing ready also produces a bubble.
  always_comb begin
    ifid_flush = 1'b0;
    ifid_hold  = 1'b0;
    ifid_load  = 1'b0;
    case (state)
      S_FETCH: begin
        if (redirect_i)        ifid_flush = 1'b1;
        else if (stall_i)      ifid_hold  = 1'b1;
        else if (imem_ready_i) ifid_load  = 1'b1;
        else                   ifid_flush = 1'b1;
      end
      default: ifid_flush = 1'b1;
    endcase
  end

  // A redirect that arrives while a fetch is outstanding cannot change the
  // address, so it is parked in pend_pc (S_DRAIN) until the memory answers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      pend_pc <= RESET_PC;
      req_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (redirect_i) pc <= redirect_pc_i;
          state <= S_FETCH;
          req_q <= 1'b1;
        end
        S_FETCH: begin
          if (redirect_i) begin
            if (imem_ready_i) begin
              pc <= redirect_pc_i;
            end else begin
              pend_pc <= redirect_pc_i;
              state   <= S_DRAIN;
            end
          end else if (!stall_i && imem_ready_i) begin
            pc <= pc_plus4;
          end
        end
        S_DRAIN: begin
          if (redirect_i) pend_pc <= redirect_pc_i;
          if (imem_ready_i) begin
            pc    <= redirect_i ? redirect_pc_i : pend_pc;
            state <= S_FETCH;
          end
        end
        default: begin
          state <= S_IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  ifid_reg u_ifid (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (ifid_flush),
    .hold    (ifid_hold),
    .load    (ifid_load),
    .pc_d    (pc),
    .pc4_d   (pc_plus4),
    .instr_d (imem_rdata_i),
    .valid_q (ifid_valid_o),
    .pc_q    (ifid_pc_o),
    .pc4_q   (ifid_pc4_o),
    .instr_q (ifid_instr_o)
  );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import cpu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        stall_i, redirect_i, imem_ready_i;
  logic [31:0] redirect_pc_i, imem_rdata_i;
  logic        imem_req_o, ifid_valid_o;
  logic [31:0] imem_addr_o, pc_o, pc_plus4_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o;
  logic [STATE_W-1:0] state_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic        watch_80;
  logic        saw_80;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ready_i  (imem_ready_i),
    .imem_rdata_i  (imem_rdata_i),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .ifid_valid_o  (ifid_valid_o),
    .ifid_pc_o     (ifid_pc_o),
    .ifid_pc4_o    (ifid_pc4_o),
    .ifid_instr_o  (ifid_instr_o),
    .state_o       (state_o)
  );

  // Instruction memory model: word depends on the requested address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction
  assign imem_rdata_i = mem_word(imem_addr_o);

  // Records whether address 0x80 is ever requested during the drain test.
  always @(negedge clk)
    if (watch_80 && imem_req_o && imem_addr_o == 32'h80) saw_80 <= 1'b1;

  // ---------------- driver ----------------
  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0;
    redirect_pc_i = '0; imem_ready_i = 1'b1;
    step(); step();
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc_o, 32'h0); end
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req_o); end
    checks++; if (ifid_valid_o !== 1'b0 || ifid_instr_o !== 32'h0 || ifid_pc_o !== 32'h0)
      begin errors++; $display("FAIL reset_ifid: got v=%b pc=%h instr=%h expected all 0", ifid_valid_o, ifid_pc_o, ifid_instr_o); end
    checks++; if (state_o !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_o, S_IDLE); end
  endtask

  task automatic test_throughput();
    logic [31:0] e;
    rst_n = 1'b1;            // cycle 0 follows: S_IDLE
    step();                  // cycle 1: S_FETCH, no instruction yet
    checks++; if (state_o !== S_FETCH || imem_req_o !== 1'b1 || ifid_valid_o !== 1'b0)
      begin errors++; $display("FAIL first_fetch: got st=%0d req=%b v=%b expected st=1 req=1 v=0", state_o, imem_req_o, ifid_valid_o); end
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    while (exp_q.size() != 0) begin
      step();
      e = exp_q.pop_front();
      checks++; if (ifid_valid_o !== 1'b1 || ifid_pc_o !== e || ifid_pc4_o !== e + 32'd4 || ifid_instr_o !== mem_word(e))
        begin errors++; $display("FAIL stream: got v=%b pc=%h pc4=%h instr=%h expected pc=%h", ifid_valid_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o, e); end
    end
    checks++; if (pc_o !== 32'h10) begin errors++; $display("FAIL stream_pc: got %h expected %h", pc_o, 32'h10); end
  endtask

  task automatic test_stall();
    stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (pc_o !== 32'h10 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h10)
        begin errors++; $display("FAIL stall_pc: got pc=%h req=%b addr=%h expected pc=10 req=1", pc_o, imem_req_o, imem_addr_o); end
      checks++; if (ifid_valid_o !== 1'b1 || ifid_pc_o !== 32'hC || ifid_instr_o !== mem_word(32'hC))
        begin errors++; $display("FAIL stall_ifid: got v=%b pc=%h instr=%h expected pc=c", ifid_valid_o, ifid_pc_o, ifid_instr_o); end
    end
    stall_i = 1'b0;
    step();
    checks++; if (ifid_pc_o !== 32'h10 || ifid_instr_o !== mem_word(32'h10) || pc_o !== 32'h14)
      begin errors++; $display("FAIL stall_resume: got ifid_pc=%h pc=%h expected 10 / 14", ifid_pc_o, pc_o); end
  endtask

  task automatic test_redirect();
    redirect_i = 1'b1; redirect_pc_i = 32'h40;
    step();
    redirect_i = 1'b0;
    checks++; if (ifid_valid_o !== 1'b0 || ifid_instr_o !== NOP_INSTR || pc_o !== 32'h40)
      begin errors++; $display("FAIL redirect_bubble: got v=%b instr=%h pc=%h expected 0/0/40", ifid_valid_o, ifid_instr_o, pc_o); end
    step();
    checks++; if (ifid_valid_o !== 1'b1 || ifid_pc_o !== 32'h40 || ifid_instr_o !== mem_word(32'h40))
      begin errors++; $display("FAIL redirect_target: got v=%b pc=%h instr=%h expected pc=40", ifid_valid_o, ifid_pc_o, ifid_instr_o); end
  endtask

  task automatic test_drain();
    // pc is 0x44 here
    saw_80 = 1'b0; watch_80 = 1'b1;
    imem_ready_i = 1'b0;
    step();                                           // wait 0: bubble
    checks++; if (ifid_valid_o !== 1'b0 || state_o !== S_FETCH || imem_addr_o !== 32'h44)
      begin errors++; $display("FAIL wait_bubble: got v=%b st=%0d addr=%h expected 0/1/44", ifid_valid_o, state_o, imem_addr_o); end
    redirect_i = 1'b1; redirect_pc_i = 32'h80;
    step();                                           // wait 1: redirect parked
    checks++; if (state_o !== S_DRAIN || imem_addr_o !== 32'h44 || imem_req_o !== 1'b1)
      begin errors++; $display("FAIL drain_enter: got st=%0d addr=%h req=%b expected 2/44/1", state_o, imem_addr_o, imem_req_o); end
    redirect_pc_i = 32'h90;
    step();                                           // wait 2: latest wins
    redirect_i = 1'b0;
    checks++; if (state_o !== S_DRAIN || imem_addr_o !== 32'h44 || ifid_valid_o !== 1'b0)
      begin errors++; $display("FAIL drain_hold: got st=%0d addr=%h v=%b expected 2/44/0", state_o, imem_addr_o, ifid_valid_o); end
    imem_ready_i = 1'b1; stall_i = 1'b1;              // stall ignored in drain
    step();
    stall_i = 1'b0;
    checks++; if (state_o !== S_FETCH || pc_o !== 32'h90 || ifid_valid_o !== 1'b0)
      begin errors++; $display("FAIL drain_exit: got st=%0d pc=%h v=%b expected 1/90/0", state_o, pc_o, ifid_valid_o); end
    step();
    checks++; if (ifid_valid_o !== 1'b1 || ifid_pc_o !== 32'h90 || ifid_instr_o !== mem_word(32'h90))
      begin errors++; $display("FAIL drain_target: got v=%b pc=%h expected pc=90", ifid_valid_o, ifid_pc_o); end
    watch_80 = 1'b0;
    checks++; if (saw_80 !== 1'b0) begin errors++; $display("FAIL never_80: got %b expected 0", saw_80); end
  endtask

  task automatic test_reset_in_drain();
    imem_ready_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h100;
    step();
    redirect_i = 1'b0;
    checks++; if (state_o !== S_DRAIN) begin errors++; $display("FAIL rd_enter: got %0d expected %0d", state_o, S_DRAIN); end
    rst_n = 1'b0; imem_ready_i = 1'b1;
    step();
    checks++; if (pc_o !== 32'h0 || imem_req_o !== 1'b0 || ifid_valid_o !== 1'b0 || state_o !== S_IDLE)
      begin errors++; $display("FAIL rd_reset: got pc=%h req=%b v=%b st=%0d expected 0/0/0/0", pc_o, imem_req_o, ifid_valid_o, state_o); end
    rst_n = 1'b1;
    step(); step();
    checks++; if (ifid_valid_o !== 1'b1 || ifid_pc_o !== 32'h0 || pc_o !== 32'h4)
      begin errors++; $display("FAIL rd_restart: got v=%b ifid_pc=%h pc=%h expected 1/0/4", ifid_valid_o, ifid_pc_o, pc_o); end
  endtask

  task automatic test_wrap();
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    step();
    redirect_i = 1'b0;
    checks++; if (pc_o !== 32'hFFFF_FFFC || pc_plus4_o !== 32'h0)
      begin errors++; $display("FAIL wrap_pc4: got pc=%h pc4=%h expected fffffffc/0", pc_o, pc_plus4_o); end
    step();
    checks++; if (pc_o !== 32'h0 || ifid_pc_o !== 32'hFFFF_FFFC || ifid_pc4_o !== 32'h0)
      begin errors++; $display("FAIL wrap_next: got pc=%h ifid_pc=%h ifid_pc4=%h expected 0/fffffffc/0", pc_o, ifid_pc_o, ifid_pc4_o); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    watch_80 = 1'b0; saw_80 = 1'b0;
    test_reset();
    test_throughput();
    test_stall();
    test_redirect();
    test_drain();
    test_reset_in_drain();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the five-stage pipelined CPU. It owns the PC register and the IF/ID pipeline register, and drives the instruction-memory request handshake. It produces the sequential next-PC (PC+4) that feeds the next-PC select and consumes the resulting redirect (jump/branch target plus IF.Flush). It is the sequential consumer at the far end of the next-PC path: stall, flush and redirect from ID/hazard logic all resolve here.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- stall_i  in  1  load-use stall from hazard unit; freezes PC and IF/ID
- redirect_i  in  1  IF.Flush: taken branch/jump resolved in ID
- redirect_pc_i  in  32  redirect target
- imem_req_o  out  1  instruction fetch request
- imem_addr_o  out  32  fetch address; equals pc_o
- imem_ready_i  in  1  fetch complete this cycle; data valid (may be same cycle as req)
- imem_rdata_i  in  32  instruction word
- pc_o  out  32  current PC register
- pc_plus4_o  out  32  pc_o + 4, combinational, wraps mod 2^32
- ifid_valid_o  out  1  IF/ID holds a real instruction
- ifid_pc_o  out  32  PC of IF/ID instruction
- ifid_pc4_o  out  32  PC+4 of IF/ID instruction
- ifid_instr_o  out  32  IF/ID instruction; 32'h0 (NOP) when flushed

## Operation
- States: S_IDLE, S_FETCH, S_DRAIN.
- Reset (rst_n=0 at edge): pc=RESET_PC, state=S_IDLE, all ifid_* = 0, imem_req_o=0. rst_n wins over all other inputs, including mid-fetch; an outstanding fetch is abandoned.
- S_IDLE: imem_req_o=0. Next cycle → S_FETCH unconditionally. redirect_i here loads pc <= redirect_pc_i.
- S_FETCH: imem_req_o=1, imem_addr_o=pc. Priority per edge: redirect > stall > ready.
  - redirect_i=1, ready=1: IF/ID flushed (valid=0, instr=0); pc <= redirect_pc_i; stay S_FETCH.
  - redirect_i=1, ready=0: IF/ID flushed; pend_pc <= redirect_pc_i; → S_DRAIN.
  - stall_i=1: pc and IF/ID hold; any returned data discarded; request stays asserted on the same address.
  - ready=1: IF/ID <= {1, pc, pc+4, imem_rdata_i}; pc <= pc+4.
  - ready=0: IF/ID valid <= 0, instr <= 0 (bubble); pc holds.
- S_DRAIN: imem_req_o=1, address held at old pc (request may not change before ready). IF/ID valid=0. redirect_i updates pend_pc (latest wins). stall_i is ignored. On ready: data discarded, pc <= pend_pc (or redirect_pc_i if redirect_i is asserted that same cycle), → S_FETCH.
- Arithmetic: all PC math is 32-bit unsigned and wraps (32'hFFFF_FFFC + 4 = 0). Bits [1:0] of redirect_pc_i are passed through unchanged; alignment is the producer's responsibility.

## Timing
- imem contract: imem_req_o and imem_addr_o are stable from assertion until the cycle with imem_ready_i=1 inclusive. Zero-wait memory (ready tied 1) is legal.
- Throughput: one instruction per cycle with ready=1, no stall.
- Latency: rst_n released before edge 0 → S_IDLE during cycle 0, S_FETCH in cycle 1, first ifid_valid_o=1 in cycle 2 with ifid_pc_o=RESET_PC.
- Redirect penalty: redirect_i in cycle n → IF/ID bubble in n+1; target instruction in IF/ID in n+2 (zero-wait memory).
- All outputs except pc_plus4_o and imem_addr_o (combinational from pc) are registered.

## Structure
- Shared package cpu_pkg: state encoding localparams, NOP_INSTR=32'h0, default RESET_PC, PC_INC=4.
- One sub-module: ifid_reg. It is the IF/ID register with hold (stall) and flush inputs; flush beats hold. The PC register, pend_pc and the FSM live in fetch_unit.

## Test plan
- Reset then ready=1 for 4 cycles, RESET_PC=0 → ifid_pc_o = 0, 4, 8 in cycles 2, 3, 4; valid=1; instr equals memory model words.
- stall_i=1 for 2 cycles in steady state at pc=0x10 → pc_o stays 0x10, IF/ID unchanged, req held; resumes with 0x10 after release.
- redirect_i=1 to 0x40 with ready=1 → next cycle valid=0, instr=0; following cycle ifid_pc_o=0x40.
- ready=0 (3 wait states), redirect to 0x80 in wait 1, redirect to 0x90 in wait 2 → addr held at old pc until ready; then fetch at 0x90; 0x80 is never fetched.
- rst_n=0 while in S_DRAIN → next cycle pc_o=RESET_PC, req=0, valid=0.
- pc=0xFFFF_FFFC, ready=1 → pc_plus4_o=0, next pc_o=0.
